// File: rtl/cache_refill_ctrl.sv
// Miss/writeback sequencer: moves one cache line between data memory and system bus, word by word.
// Latency: clean miss N+1 cycles to line_refill; dirty miss adds 2N+1 (read+write per writeback word).
// Backpressure: each bus beat waits for bus_ack with address/data held; core_stall high while busy.
module cache_refill_ctrl #(
  parameter int ENTRY_NUM  = 8,
  parameter int SEL_WIDTH  = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1,
  parameter int LINE_WORDS = 16,
  parameter int LINE_BITS  = $clog2(LINE_WORDS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           line_miss,
  input  logic                           replace_dirty,
  input  logic [SEL_WIDTH-1:0]           replace_sel,
  input  logic [31:0]                    access_addr,
  input  logic [31:0]                    victim_pa,
  input  logic                           sync_req,
  output logic                           core_stall,
  output logic                           sync_done,
  output logic                           force_sync,
  output logic                           writeback_ok,
  output logic                           line_refill,
  output logic [31:0]                    refill_pa,
  output logic [SEL_WIDTH+LINE_BITS-1:0] cmem_addr,
  output logic                           cmem_we,
  output logic [31:0]                    cmem_wdata,
  input  logic [31:0]                    cmem_rdata,
  output logic                           bus_req,
  output logic                           bus_we,
  output logic [31:0]                    bus_addr,
  output logic [31:0]                    bus_wdata,
  input  logic [31:0]                    bus_rdata,
  input  logic                           bus_ack
);

  typedef enum logic [2:0] {
    S_IDLE, S_WB_RD, S_WB_BUS, S_WB_DONE, S_RF_BUS, S_RF_DONE, S_SYNC_CHK
  } state_t;

  // Byte offset bits inside one line; cleared to form a line base address.
  localparam logic [31:0] LINE_MASK = 32'(LINE_WORDS * 4 - 1);

  state_t                         r_state;
  state_t                         w_state_nxt;
  logic [LINE_BITS-1:0]           r_idx;
  logic [SEL_WIDTH-1:0]           r_sel_q;
  logic [31:0]                    r_wb_base_q;
  logic [31:0]                    r_rf_base_q;
  logic [31:0]                    r_wdata_q;
  logic                           r_sync_q;

  logic                           w_cap_miss;
  logic                           w_cap_victim;
  logic                           w_idx_clr;
  logic                           w_idx_inc;
  logic                           w_cap_wdata;
  logic                           w_set_sync;
  logic                           w_clr_sync;
  logic                           w_last;
  logic [31:0]                    w_ofs;
  logic [31:0]                    w_victim_base;
  logic [31:0]                    w_access_base;
  logic [SEL_WIDTH+LINE_BITS-1:0] w_cmem_addr;

  assign w_last        = (r_idx == LINE_BITS'(LINE_WORDS - 1));
  assign w_ofs         = {{(30 - LINE_BITS){1'b0}}, r_idx, 2'b00};
  assign w_victim_base = victim_pa & ~LINE_MASK;
  assign w_access_base = access_addr & ~LINE_MASK;
  assign w_cmem_addr   = {r_sel_q, r_idx};

  assign core_stall = (r_state != S_IDLE) | line_miss | sync_req;
  assign force_sync = r_sync_q;

  // State register; reset aborts any burst in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state, load enables and all sequencer outputs.
  always_comb begin
    w_state_nxt  = r_state;
    w_cap_miss   = 1'b0;
    w_cap_victim = 1'b0;
    w_idx_clr    = 1'b0;
    w_idx_inc    = 1'b0;
    w_cap_wdata  = 1'b0;
    w_set_sync   = 1'b0;
    w_clr_sync   = 1'b0;
    cmem_addr    = '0;
    cmem_we      = 1'b0;
    cmem_wdata   = '0;
    bus_req      = 1'b0;
    bus_we       = 1'b0;
    bus_addr     = '0;
    bus_wdata    = '0;
    writeback_ok = 1'b0;
    line_refill  = 1'b0;
    refill_pa    = '0;
    sync_done    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // A miss wins over a flush request; the flush is picked up afterwards.
        if (line_miss) begin
          w_cap_miss  = 1'b1;
          w_idx_clr   = 1'b1;
          w_state_nxt = replace_dirty ? S_WB_RD : S_RF_BUS;
        end else if (sync_req) begin
          w_set_sync  = 1'b1;
          w_state_nxt = S_SYNC_CHK;
        end
      end
      S_WB_RD: begin
        // Memory returns the word within this cycle; it is registered at the edge.
        cmem_addr   = w_cmem_addr;
        w_cap_wdata = 1'b1;
        w_state_nxt = S_WB_BUS;
      end
      S_WB_BUS: begin
        bus_req   = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = r_wb_base_q + w_ofs;
        bus_wdata = r_wdata_q;
        if (bus_ack) begin
          w_idx_inc   = 1'b1;
          w_state_nxt = w_last ? S_WB_DONE : S_WB_RD;
        end
      end
      S_WB_DONE: begin
        writeback_ok = 1'b1;
        w_state_nxt  = r_sync_q ? S_SYNC_CHK : S_RF_BUS;
      end
      S_RF_BUS: begin
        bus_req  = 1'b1;
        bus_addr = r_rf_base_q + w_ofs;
        if (bus_ack) begin
          cmem_we    = 1'b1;
          cmem_addr  = w_cmem_addr;
          cmem_wdata = bus_rdata;
          w_idx_inc  = 1'b1;
          if (w_last) w_state_nxt = S_RF_DONE;
        end
      end
      S_RF_DONE: begin
        line_refill = 1'b1;
        refill_pa   = r_rf_base_q;
        w_state_nxt = S_IDLE;
      end
      S_SYNC_CHK: begin
        if (replace_dirty) begin
          w_cap_victim = 1'b1;
          w_idx_clr    = 1'b1;
          w_state_nxt  = S_WB_RD;
        end else begin
          sync_done   = 1'b1;
          w_clr_sync  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath registers: word index, captured line bases, writeback data and flush flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_sel_q     <= '0;
      r_wb_base_q <= '0;
      r_rf_base_q <= '0;
      r_wdata_q   <= '0;
      r_sync_q    <= 1'b0;
    end else begin
      if (w_idx_clr)      r_idx <= '0;
      else if (w_idx_inc) r_idx <= r_idx + 1'b1;
      if (w_cap_miss) begin
        r_sel_q     <= replace_sel;
        r_wb_base_q <= w_victim_base;
        r_rf_base_q <= w_access_base;
      end else if (w_cap_victim) begin
        r_sel_q     <= replace_sel;
        r_wb_base_q <= w_victim_base;
      end
      if (w_cap_wdata) r_wdata_q <= cmem_rdata;
      if (w_set_sync)      r_sync_q <= 1'b1;
      else if (w_clr_sync) r_sync_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Bench for cache_refill_ctrl: random-address misses, wait states, flush, miss+flush, reset abort.
// Expected bursts and pulse cycles come from line arithmetic on the stimulus, not from the DUT.
// Bus acks are zero-wait or random 0..5 wait states per beat.
module tb_cache_refill_ctrl;
  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        line_miss, sync_req;
  logic        replace_dirty;
  logic [2:0]  replace_sel;
  logic [31:0] access_addr, victim_pa;
  logic        core_stall, sync_done, force_sync, writeback_ok, line_refill;
  logic [31:0] refill_pa;
  logic [6:0]  cmem_addr;
  logic        cmem_we;
  logic [31:0] cmem_wdata, cmem_rdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_ack = 1'b0;

  // Stimulus-side knobs (main process only).
  logic        miss_dirty;
  logic [2:0]  miss_sel;
  logic [31:0] miss_victim;
  logic        flush_mode, ack_mode, watch_stall;
  int          flush_base, flush_n;
  logic [31:0] salt;

  // Observation state (monitor process only).
  typedef struct { int cyc; logic we; logic [31:0] addr; logic [31:0] dat; } beat_t;
  typedef struct { int cyc; logic [6:0] addr; logic [31:0] dat; } cw_t;
  beat_t       beat_q[$];
  cw_t         cw_q[$];
  int          wbok_cyc[$];
  int          rf_cyc[$];
  logic [31:0] rf_pa[$];
  int          sd_cyc[$];
  int          wb_pulses = 0;
  int          fs_low = 0;
  int          stall_low = 0;
  int          wait_left = 0;
  logic        have_held = 1'b0;
  logic [31:0] held_addr, held_wdata;

  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;

  // Memory models: cache contents tagged by address, bus returns address xor salt.
  assign cmem_rdata = 32'hC0DE_0000 | {25'd0, cmem_addr};
  assign bus_rdata  = bus_addr ^ salt;

  // Tag-arbiter model: during a flush, entries 2 then 5 are dirty until their writeback_ok.
  int flush_k;
  assign flush_k       = wb_pulses - flush_base;
  assign replace_dirty = flush_mode ? (flush_k < flush_n) : miss_dirty;
  assign replace_sel   = flush_mode ? ((flush_k == 0) ? 3'd2 : 3'd5) : miss_sel;
  assign victim_pa     = flush_mode ? (32'h0001_0000 + {21'd0, replace_sel, 8'd0}) : miss_victim;

  cache_refill_ctrl #(.ENTRY_NUM(8), .LINE_WORDS(N)) dut (
    .clk(clk), .rst_n(rst_n), .line_miss(line_miss), .replace_dirty(replace_dirty),
    .replace_sel(replace_sel), .access_addr(access_addr), .victim_pa(victim_pa),
    .sync_req(sync_req), .core_stall(core_stall), .sync_done(sync_done),
    .force_sync(force_sync), .writeback_ok(writeback_ok), .line_refill(line_refill),
    .refill_pa(refill_pa), .cmem_addr(cmem_addr), .cmem_we(cmem_we),
    .cmem_wdata(cmem_wdata), .cmem_rdata(cmem_rdata), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] init_word(input int a);
    return 32'hC0DE_0000 + 32'(a);
  endfunction

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return a ^ salt;
  endfunction

  function automatic logic [31:0] line_base(input logic [31:0] a);
    return a - (a % 64);
  endfunction

  // Bus slave + monitor: choose ack at the falling edge, then sample settled outputs.
  always @(negedge clk) begin
    beat_t b;
    cw_t   c;
    if (ack_mode == 1'b0)    bus_ack = 1'b1;
    else if (!bus_req)       bus_ack = 1'b0;
    else if (wait_left == 0) bus_ack = 1'b1;
    else begin
      bus_ack = 1'b0;
      wait_left--;
    end
    #1;
    if (!rst_n) have_held = 1'b0;
    else begin
      if (bus_req) begin
        if (have_held) begin
          chk("hold_addr", bus_addr, held_addr);
          chk("hold_wdata", bus_wdata, held_wdata);
        end
        if (bus_ack) begin
          b.cyc = cyc; b.we = bus_we; b.addr = bus_addr; b.dat = bus_wdata;
          beat_q.push_back(b);
          have_held = 1'b0;
          if (ack_mode) wait_left = $urandom_range(0, 5);
        end else begin
          held_addr  = bus_addr;
          held_wdata = bus_wdata;
          have_held  = 1'b1;
        end
      end else have_held = 1'b0;
      if (cmem_we) begin
        c.cyc = cyc; c.addr = cmem_addr; c.dat = cmem_wdata;
        cw_q.push_back(c);
      end
      if (writeback_ok) begin
        wbok_cyc.push_back(cyc);
        wb_pulses++;
      end
      if (line_refill) begin
        rf_cyc.push_back(cyc);
        rf_pa.push_back(refill_pa);
      end
      if (sync_done) sd_cyc.push_back(cyc);
      if (sync_req && !force_sync) fs_low++;
      if (watch_stall && !core_stall) stall_low++;
    end
  end

  task automatic next_cyc();
    @(negedge clk);
    #2;
  endtask

  task automatic run_miss(input logic dirty, input logic [2:0] sel, input logic [31:0] vpa,
                          input logic [31:0] addr, input logic zw);
    int bb, cb, wb, rb, c0, nexp, w;
    logic [31:0] wbase, rbase, ea, ed;
    logic ewe;
    bb = beat_q.size(); cb = cw_q.size(); wb = wbok_cyc.size(); rb = rf_cyc.size();
    wbase = line_base(vpa);
    rbase = line_base(addr);
    miss_dirty = dirty; miss_sel = sel; miss_victim = vpa; access_addr = addr;
    line_miss = 1'b1;
    c0 = cyc;
    next_cyc();
    // Tag-side inputs wander after the miss is taken; only the captured values may matter.
    line_miss = 1'b0;
    miss_dirty = 1'($urandom_range(0, 1)); miss_sel = 3'($urandom_range(0, 7));
    miss_victim = $urandom; access_addr = $urandom;
    for (int i = 0; i < 2000 && rf_cyc.size() == rb; i++) next_cyc();
    miss_dirty = 1'b0;
    next_cyc();
    chk("idle_stall", 32'(core_stall), 32'd0);
    nexp = dirty ? 2 * N : N;
    chk("beat_cnt", beat_q.size() - bb, nexp);
    for (int i = 0; i < nexp && bb + i < beat_q.size(); i++) begin
      ewe = dirty && (i < N);
      w   = dirty ? (i % N) : i;
      ea  = (ewe ? wbase : rbase) + 32'(4 * w);
      ed  = init_word(sel * N + w);
      chk("beat_we", 32'(beat_q[bb + i].we), 32'(ewe));
      chk("beat_addr", beat_q[bb + i].addr, ea);
      if (ewe) chk("beat_wdata", beat_q[bb + i].dat, ed);
    end
    chk("cmem_cnt", cw_q.size() - cb, N);
    for (int i = 0; i < N && cb + i < cw_q.size(); i++) begin
      chk("cmem_addr", 32'(cw_q[cb + i].addr), 32'(sel * N + i));
      chk("cmem_data", cw_q[cb + i].dat, rd_model(rbase + 32'(4 * i)));
    end
    chk("wbok_cnt", wbok_cyc.size() - wb, 32'(dirty));
    chk("refill_cnt", rf_cyc.size() - rb, 1);
    if (rf_cyc.size() > rb) chk("refill_pa", rf_pa[rb], rbase);
    if (zw) begin
      if (rf_cyc.size() > rb) chk("refill_cyc", rf_cyc[rb] - c0, dirty ? 3 * N + 2 : N + 1);
      if (dirty && wbok_cyc.size() > wb) chk("wbok_cyc", wbok_cyc[wb] - c0, 2 * N + 1);
      if (cw_q.size() >= cb + N) begin
        chk("cmem_first_cyc", cw_q[cb].cyc - c0, dirty ? 2 * N + 2 : 1);
        chk("cmem_last_cyc", cw_q[cb + N - 1].cyc - c0, dirty ? 3 * N + 1 : N);
      end
    end
  endtask

  initial begin
    int bb, wb, rb, sb, cb, fl, sl, c0;
    logic [31:0] rbase;
    rst_n = 1'b0; line_miss = 1'b0; sync_req = 1'b0; access_addr = '0;
    miss_dirty = 1'b0; miss_sel = '0; miss_victim = '0;
    flush_mode = 1'b0; flush_n = 0; flush_base = 0; ack_mode = 1'b0; watch_stall = 1'b0;
    salt = 32'h5A5A_0000;
    #1;
    chk("rst_bus_req", 32'(bus_req), 0);
    chk("rst_cmem_we", 32'(cmem_we), 0);
    chk("rst_stall", 32'(core_stall), 0);
    chk("rst_force_sync", 32'(force_sync), 0);
    chk("rst_bus_addr", bus_addr, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    next_cyc();

    // Clean and dirty misses with zero-wait acks; line-base arithmetic on odd addresses.
    run_miss(1'b0, 3'd1, 32'h0000_0000, 32'h0000_1234, 1'b1);
    run_miss(1'b1, 3'd3, 32'h0000_8000, 32'h0000_2468, 1'b1);
    run_miss(1'b1, 3'd7, 32'hFFFF_FFFF, 32'hABCD_EF01, 1'b1);

    // Random addresses, entries and wait states.
    ack_mode = 1'b1;
    for (int t = 0; t < 4; t++) begin
      salt = $urandom;
      run_miss(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom, 1'b0);
    end
    ack_mode = 1'b0;

    // Flush with entries 2 and 5 dirty.
    bb = beat_q.size(); wb = wbok_cyc.size(); sb = sd_cyc.size(); fl = fs_low; sl = stall_low;
    flush_base = wb_pulses; flush_n = 2; flush_mode = 1'b1; sync_req = 1'b1; watch_stall = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 3000; i++) begin
      next_cyc();
      if (sync_done) break;
    end
    sync_req = 1'b0; flush_mode = 1'b0; watch_stall = 1'b0;
    next_cyc(); next_cyc();
    chk("fl_beat_cnt", beat_q.size() - bb, 2 * N);
    for (int i = 0; i < 2 * N && bb + i < beat_q.size(); i++) begin
      chk("fl_beat_we", 32'(beat_q[bb + i].we), 1);
      chk("fl_beat_addr", beat_q[bb + i].addr,
          32'h0001_0000 + 32'((i < N ? 2 : 5) * 256 + 4 * (i % N)));
      chk("fl_beat_wdata", beat_q[bb + i].dat, init_word((i < N ? 2 : 5) * N + i % N));
    end
    chk("fl_wbok_cnt", wbok_cyc.size() - wb, 2);
    for (int k = 0; k < 2 && wb + k < wbok_cyc.size(); k++)
      chk("fl_wbok_cyc", wbok_cyc[wb + k] - c0, (k + 1) * (2 * N + 2));
    chk("fl_done_cnt", sd_cyc.size() - sb, 1);
    if (sd_cyc.size() > sb) chk("fl_done_cyc", sd_cyc[sb] - c0, 2 * (2 * N + 2) + 1);
    chk("fl_force_low", fs_low - fl, 0);
    chk("fl_stall_low", stall_low - sl, 0);
    chk("fl_force_end", 32'(force_sync), 0);

    // Miss and flush request in the same cycle: refill first, then an empty flush.
    rb = rf_cyc.size(); sb = sd_cyc.size(); cb = cw_q.size(); wb = wbok_cyc.size();
    fl = fs_low; sl = stall_low;
    flush_base = wb_pulses; flush_n = 0; flush_mode = 1'b1;
    access_addr = 32'h0000_7777;
    line_miss = 1'b1; sync_req = 1'b1; watch_stall = 1'b1;
    c0 = cyc;
    next_cyc();
    line_miss = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (sync_done) break;
      next_cyc();
    end
    sync_req = 1'b0; flush_mode = 1'b0; watch_stall = 1'b0;
    next_cyc(); next_cyc();
    chk("ms_refill_cnt", rf_cyc.size() - rb, 1);
    if (rf_cyc.size() > rb) begin
      chk("ms_refill_cyc", rf_cyc[rb] - c0, N + 1);
      chk("ms_refill_pa", rf_pa[rb], 32'h0000_7740);
    end
    chk("ms_cmem_cnt", cw_q.size() - cb, N);
    if (cw_q.size() > cb) chk("ms_cmem_addr0", 32'(cw_q[cb].addr), 32'(2 * N));
    chk("ms_wbok_cnt", wbok_cyc.size() - wb, 0);
    chk("ms_done_cnt", sd_cyc.size() - sb, 1);
    if (sd_cyc.size() > sb) chk("ms_done_cyc", sd_cyc[sb] - c0, N + 3);
    chk("ms_force_low", fs_low - fl, N + 2);
    chk("ms_stall_low", stall_low - sl, 0);

    // Reset in the middle of a refill (word 7).
    rb = rf_cyc.size();
    rbase = 32'h0000_4A40;
    miss_dirty = 1'b0; miss_sel = 3'd4; access_addr = 32'h0000_4A7C;
    line_miss = 1'b1;
    next_cyc();
    line_miss = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus_req && bus_addr == rbase + 32'd28) break;
      next_cyc();
    end
    chk("rs_at_word7", bus_addr, rbase + 32'd28);
    rst_n = 1'b0;
    #1;
    chk("rs_bus_req", 32'(bus_req), 0);
    chk("rs_bus_we", 32'(bus_we), 0);
    chk("rs_bus_addr", bus_addr, 0);
    chk("rs_bus_wdata", bus_wdata, 0);
    chk("rs_cmem_we", 32'(cmem_we), 0);
    chk("rs_cmem_addr", 32'(cmem_addr), 0);
    chk("rs_cmem_wdata", cmem_wdata, 0);
    chk("rs_refill", 32'(line_refill), 0);
    chk("rs_refill_pa", refill_pa, 0);
    chk("rs_wbok", 32'(writeback_ok), 0);
    chk("rs_sync_done", 32'(sync_done), 0);
    chk("rs_force_sync", 32'(force_sync), 0);
    chk("rs_stall", 32'(core_stall), 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    next_cyc(); next_cyc();
    chk("rs_no_refill", rf_cyc.size() - rb, 0);
    run_miss(1'b0, 3'd4, 32'h0000_0000, 32'h0000_4A7C, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/cache_refill_ctrl.md
# cache_refill_ctrl

Miss/writeback sequencer for the BIU cache. Sits between `tag_arbiter`, the cache data memory and the system bus. Turns `line_miss`, `replace_dirty` and core flush requests into word-by-word bus bursts, and returns `writeback_ok`, `line_refill`, `refill_pa` and `force_sync` to the tag arbiter. Stalls the core while a line transfer is in progress.

## Interface
- `ENTRY_NUM`, 8, cache line (entry) count; must match `tag_arbiter`.
- `SEL_WIDTH`, `$clog2(ENTRY_NUM)` (1 if `ENTRY_NUM` = 1), entry select width.
- `LINE_WORDS`, 16, 32-bit words per line; power of 2, ≥2.
- `LINE_BITS`, `$clog2(LINE_WORDS)`, word-index width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `line_miss` in 1: from tag arbiter.
- `replace_dirty` in 1: from tag arbiter.
- `replace_sel` in SEL_WIDTH: `entry_replace_sel` from tag arbiter.
- `access_addr` in 32: core access address.
- `victim_pa` in 32: line base PA of the entry at `replace_sel`, from tag store.
- `sync_req` in 1: level flush request; held until `sync_done`.
- `core_stall` out 1: core must hold its access.
- `sync_done` out 1: one-cycle pulse, flush complete.
- `force_sync` out 1: to tag arbiter.
- `writeback_ok` out 1: one-cycle pulse to tag arbiter.
- `line_refill` out 1: one-cycle pulse to tag arbiter.
- `refill_pa` out 32: line base PA for refill.
- `cmem_addr` out SEL_WIDTH+LINE_BITS: `{entry, word}`.
- `cmem_we` out 1: cache write enable.
- `cmem_wdata` out 32: cache write data.
- `cmem_rdata` in 32: cache read data, 1-cycle read latency.
- `bus_req` out 1: bus request.
- `bus_we` out 1: bus write enable.
- `bus_addr` out 32: word-aligned bus address.
- `bus_wdata` out 32: bus write data.
- `bus_rdata` in 32: bus read data.
- `bus_ack` in 1: beat complete when `bus_req` and `bus_ack` are both high at a rising edge.

## Operation
- Registers: `state`, `idx[LINE_BITS-1:0]`, `sel_q`, `wb_base_q`, `rf_base_q`, `wdata_q`, `sync_q`.
- **IDLE**
  - If `line_miss`: capture `sel_q`=`replace_sel`, `wb_base_q`=`victim_pa` with low LINE_BITS+2 bits cleared, `rf_base_q`=`access_addr` with low LINE_BITS+2 bits cleared, `idx`=0.
  - Next state WB_RD if `replace_dirty`, else RF_BUS.
  - Else if `sync_req`: set `sync_q`, go SYNC_CHK.
  - A miss has priority over `sync_req` in the same cycle; the flush starts after the miss completes.
- **WB_RD**: `cmem_addr`={`sel_q`,`idx`}; next state WB_BUS. `cmem_rdata` is captured into `wdata_q` on entry to WB_BUS.
- **WB_BUS**
  - Drive `bus_req`=1, `bus_we`=1, `bus_addr`=`wb_base_q`+{`idx`,2'b00}, `bus_wdata`=`wdata_q`.
  - On `bus_ack`: `idx`++. If `idx` was LINE_WORDS-1, go WB_DONE (idx wraps to 0); else go WB_RD.
- **WB_DONE**: `writeback_ok`=1. Next state SYNC_CHK if `sync_q`, else RF_BUS.
- **RF_BUS**
  - Drive `bus_req`=1, `bus_we`=0, `bus_addr`=`rf_base_q`+{`idx`,2'b00}.
  - On `bus_ack`, same cycle: `cmem_we`=1, `cmem_addr`={`sel_q`,`idx`}, `cmem_wdata`=`bus_rdata`; then `idx`++.
  - After the last word, go RF_DONE.
- **RF_DONE**: `line_refill`=1, `refill_pa`=`rf_base_q`; next state IDLE.
- **SYNC_CHK**
  - `force_sync`=1 (also held in every state while `sync_q`=1).
  - If `replace_dirty`: capture `sel_q`=`replace_sel`, `wb_base_q`=`victim_pa`, go WB_RD.
  - Else pulse `sync_done`, clear `sync_q`, go IDLE.
- `core_stall` = (state≠IDLE) | `line_miss` | `sync_req`.
- `bus_req` is low in all states except WB_BUS and RF_BUS. All address arithmetic is 32-bit.

## Timing
- Reset (async assert): state=IDLE, `sync_q`=0, `idx`=0. All outputs 0 except `core_stall`, which follows its equation and goes low once state=IDLE with no request. A reset mid-burst aborts immediately; the line is not refilled and `line_refill` never pulses.
- While `bus_req`=1 without `bus_ack`, `bus_addr`, `bus_we` and `bus_wdata` are held stable.
- Refill beats may be back-to-back: `bus_req` stays high across consecutive acks.
- Writeback beats cost at least 2 cycles each (WB_RD + WB_BUS).
- Clean miss with zero-wait ack, miss sampled in cycle 0:
  - RF_BUS occupies cycles 1..N.
  - `line_refill` is high in cycle N+1.
  - IDLE in cycle N+2.
- Dirty miss with zero-wait ack:
  - `writeback_ok` in cycle 2N+1.
  - `line_refill` in cycle 3N+2.
- `writeback_ok`, `line_refill` and `sync_done` are exactly one cycle wide.

## Test plan
- Clean miss, N=16, `access_addr`=0x0000_1234, `bus_ack` tied high → 16 reads at 0x1200..0x123C; `cmem_we` on 16 consecutive cycles with `cmem_addr` {sel,0..15}; `line_refill` in cycle 17 with `refill_pa`=0x1200.
- Dirty miss, `victim_pa`=0x0000_8000, `replace_sel`=3 → 16 writes at 0x8000..0x803C with data from entry 3; `writeback_ok` in cycle 33; then refill; `line_refill` in cycle 50.
- Random `bus_ack` wait states of 0–5 cycles → bus outputs stable while unacked; word count and order unchanged.
- `sync_req` with entries 2 and 5 dirty → two writeback bursts, each with a `writeback_ok` pulse; `force_sync` high throughout; `sync_done` one cycle after the SYNC_CHK that sees `replace_dirty`=0.
- `line_miss` and `sync_req` rise in the same cycle → refill completes first, then the flush; `core_stall` stays high through both.
- `rst_n` low at word 7 of a refill → all outputs 0 asynchronously, no `line_refill`; the next miss restarts at word 0.
